lfsr_stream_encrypt: RTL
========================

Name: lfsr_stream_encrypt

Overview:
Encryption sequencer that sits directly downstream of the 6-bit LFSR generator and consumes its state.
- Drives the generator's init/en controls.
- Takes an ASCII plaintext stream, emits a fixed-length ciphertext frame of 6-bit symbols: preamble, then message, then pad.
- Each symbol is XORed with the current LFSR state; the LFSR advances exactly once per accepted output symbol.
- Feeds the data-memory write port of the encoder path.

Parameters:
FRAME_LEN, 64, total symbols per frame (preamble + message + pad); legal range 2..255
CW, 8, frame symbol counter width; must satisfy 2^CW > FRAME_LEN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: begin a frame (ignored unless IDLE)
seed  in  6  LFSR start state, forwarded to the LFSR on lfsr_init
taps  in  6  LFSR tap pattern, forwarded to the LFSR on lfsr_init
pre_len  in  4  preamble symbol count, sampled on start; 0 is legal
lfsr_state  in  6  current LFSR state (from the generator)
lfsr_init  out  1  force the LFSR to seed/taps
lfsr_en  out  1  advance the LFSR
lfsr_start  out  6  equals seed (combinational)
lfsr_taps  out  6  equals taps (combinational)
in_data  in  8  plaintext ASCII character
in_valid  in  1  in_data valid
in_last  in  1  marks final message character (qualified by in_valid)
in_ready  out  1  character accepted when in_valid & in_ready
out_data  out  8  ciphertext {2'b00, sym ^ lfsr_state}
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid & out_ready
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last frame symbol is accepted
err  out  1  sticky: an out-of-range character was seen in the current frame

Behaviour:
- Reset (async, immediate): state IDLE. Counters = 0. All outputs 0 except lfsr_start/lfsr_taps, which track their inputs.
- States and transitions:
  - IDLE: on start, latch pre_len, clear err and count, go to LOAD.
  - LOAD: lfsr_init=1 for exactly 1 cycle. Next state is PRE if pre_len != 0, otherwise MSG.
  - PRE: sym=6'h3F (underscore). out_valid=1. After pre_len accepted symbols, go to MSG.
  - MSG: out_valid=in_valid, in_ready=out_ready, sym=in_data-8'h20 (low 6 bits).
    - On an accepted char with in_last, go to PAD.
    - If count reaches FRAME_LEN without in_last, go to DRAIN.
  - PAD: sym=6'h00 (space), out_valid=1 until count==FRAME_LEN, then go to DONE.
  - DRAIN: out_valid=0, in_ready=1. Silently consume characters until an accepted char with in_last, then go to DONE.
  - DONE: done=1 for 1 cycle, then go to IDLE.
- Symbol transfer:
  - A transfer happens when out_valid & out_ready; the symbol counter increments on each transfer.
  - Symbol index i (0-based) is XORed with the LFSR state after i advances.
- Latency: zero-cycle combinational pass-through in MSG (in_data to out_data, out_ready to in_ready). No buffering.
- LFSR control:
  - lfsr_en = out_valid & out_ready, combinational.
  - lfsr_en is never asserted in IDLE, LOAD, DRAIN or DONE.
  - lfsr_init is never asserted together with lfsr_en.
- Range check:
  - A char outside 0x20..0x5F sets err (sticky until the next start).
  - The char is still encoded using the low 6 bits of in_data-0x20.
- Boundary cases:
  - pre_len >= FRAME_LEN: preamble truncated at FRAME_LEN, then go to DRAIN.
  - in_last on the symbol that makes count==FRAME_LEN: go to DONE, not PAD.
  - Backpressure (out_ready=0): hold out_data stable; lfsr_en=0; counters hold.
  - start while busy: ignored.
  - rst mid-frame: immediate return to IDLE; the partial frame is abandoned.

Test Plan:
- rst held, then released -> all outputs 0, busy=0.
- taps=6'h21, seed=6'h01, pre_len=4, out_ready=1, pulse start -> lfsr_init high 1 cycle; preamble out_data = 0x3E, 0x3C, 0x38, 0x30, with lfsr_en high each cycle.
- Same setup, then message "A" (0x41) with in_last -> out_data=0x3E (0x21^0x1F). Pad symbols follow until 64 symbols total, then done pulses once.
- Toggle out_ready 1/0 every cycle during PRE and MSG -> lfsr_en only on accepted cycles; output sequence identical to the unstalled run; in_ready mirrors out_ready.
- FRAME_LEN=8, pre_len=2, 10-char message -> 6 message symbols output, 4 chars drained, done only after in_last; no lfsr_en during DRAIN.
- Message containing 0x7A, then assert start mid-frame, then rst mid-PAD -> err=1 and stays set; start ignored; rst returns to IDLE immediately with outputs 0.

Source files
------------

// File: rtl/lfsr_stream_encrypt.sv
// Frame sequencer for the 6-bit LFSR stream cipher: preamble, message, pad,
// each symbol XORed with the external generator state, which advances once per accepted symbol.
module lfsr_stream_encrypt #(
  parameter int FRAME_LEN = 64,
  parameter int CW        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] seed,
  input  logic [5:0] taps,
  input  logic [3:0] pre_len,
  input  logic [5:0] lfsr_state,
  output logic       lfsr_init,
  output logic       lfsr_en,
  output logic [5:0] lfsr_start,
  output logic [5:0] lfsr_taps,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LOAD, PRE, MSG, PAD, DRAIN, DONE} state_t;

  localparam logic [CW-1:0] FL = CW'(FRAME_LEN);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    pre_rem, pre_rem_nxt;
  logic          err_nxt;
  logic          at_end, bad_char;
  logic [5:0]    sym, msg_sym;

  assign lfsr_start = seed;
  assign lfsr_taps  = taps;
  assign lfsr_en    = out_valid & out_ready;
  assign busy       = (state != IDLE);

  // Low six bits of (in_data - 0x20) only depend on the low six input bits.
  assign msg_sym  = in_data[5:0] - 6'h20;
  assign bad_char = (in_data < 8'h20) || (in_data > 8'h5F);
  // True when the symbol being accepted now is the last one of the frame.
  assign at_end   = ((cnt + 1'b1) == FL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pre_rem <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pre_rem <= pre_rem_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pre_rem_nxt = pre_rem;
    err_nxt     = err;
    out_valid   = 1'b0;
    in_ready    = 1'b0;
    lfsr_init   = 1'b0;
    done        = 1'b0;
    sym         = 6'h00;
    case (state)
      IDLE: begin
        if (start) begin
          pre_rem_nxt = pre_len;
          cnt_nxt     = '0;
          err_nxt     = 1'b0;
          state_nxt   = LOAD;
        end
      end
      LOAD: begin
        lfsr_init = 1'b1;
        state_nxt = (pre_rem != 4'd0) ? PRE : MSG;
      end
      PRE: begin
        out_valid = 1'b1;
        sym       = 6'h3F;
        if (out_ready) begin
          cnt_nxt     = cnt + 1'b1;
          pre_rem_nxt = pre_rem - 4'd1;
          // A preamble longer than the frame is cut short and the message dropped.
          if (at_end)                 state_nxt = DRAIN;
          else if (pre_rem == 4'd1)   state_nxt = MSG;
        end
      end
      MSG: begin
        out_valid = in_valid;
        in_ready  = out_ready;
        sym       = msg_sym;
        if (in_valid && out_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (bad_char) err_nxt = 1'b1;
          if (in_last)     state_nxt = at_end ? DONE : PAD;
          else if (at_end) state_nxt = DRAIN;
        end
      end
      PAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (at_end) state_nxt = DONE;
        end
      end
      DRAIN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (bad_char) err_nxt = 1'b1;
          if (in_last)  state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    out_data = out_valid ? {2'b00, sym ^ lfsr_state} : 8'h00;
  end

endmodule
